vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout_if.sv | 25 ++
 rtl/vga_scanout.sv | 106 ++++++++++
 tb/tb_vga_scanout.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Scanout-side signals: framebuffer read port, pattern select and video outputs.
// master = scanout engine, slave = framebuffer/display side.
interface vga_scanout_if;
  logic [3:0] fb_data;
  logic       pattern_en;
  logic       fb_read;
  logic       fb_reset_ptr;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       frame_start;

  modport master (
    input  fb_data, pattern_en,
    output fb_read, fb_reset_ptr, hsync, vsync, de, r, g, b, frame_start
  );

  modport slave (
    output fb_data, pattern_en,
    input  fb_read, fb_reset_ptr, hsync, vsync, de, r, g, b, frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing + framebuffer scanout: fb strobes are combinational from the counters, video out 2 cycles later.
// No backpressure: free-running at the pixel clock; the framebuffer must keep up with one read per two pixels.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_scanout_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        rst_hold;
  logic        active;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        blank_start;
  logic        de_d1;
  logic        hsync_d1;
  logic        vsync_d1;
  logic        pattern_d1;
  logic [3:0]  bar_d1;
  logic [3:0]  index;
  logic [11:0] rgb_next;

  function automatic logic [11:0] palette(input logic [3:0] i);
    if (i == 4'hF) return 12'h000;
    return {i, i[2:0], 1'b0, ~i};
  endfunction

  // rst_hold keeps fb_reset_ptr high through the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount   <= '0;
      vcount   <= '0;
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign active      = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_raw   = !((hcount >= HS_START) && (hcount < HS_END));
  assign vsync_raw   = !((vcount >= VS_START) && (vcount < VS_END));
  assign blank_start = (hcount == 10'd0) && (vcount == V_ACT);

  // Odd-column strobe: each stored pixel is shown twice, pointer advances after the pair.
  assign vif.fb_read      = active && hcount[0];
  assign vif.frame_start  = blank_start;
  assign vif.fb_reset_ptr = rst_hold || blank_start;

  assign index    = pattern_d1 ? bar_d1 : vif.fb_data;
  assign rgb_next = de_d1 ? palette(index) : 12'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d1      <= 1'b0;
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
      pattern_d1 <= 1'b0;
      bar_d1     <= '0;
      vif.de     <= 1'b0;
      vif.hsync  <= 1'b1;
      vif.vsync  <= 1'b1;
      vif.r      <= '0;
      vif.g      <= '0;
      vif.b      <= '0;
    end else begin
      de_d1      <= active;
      hsync_d1   <= hsync_raw;
      vsync_d1   <= vsync_raw;
      pattern_d1 <= vif.pattern_en;
      bar_d1     <= hcount[9:6];
      vif.de     <= de_d1;
      vif.hsync  <= hsync_d1;
      vif.vsync  <= vsync_d1;
      vif.r      <= rgb_next[11:8];
      vif.g      <= rgb_next[7:4];
      vif.b      <= rgb_next[3:0];
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced screen geometry, with a framebuffer model and a position-based reference.
module tb_vga_scanout;
  localparam int HA = 256, HFP = 8, HS = 16, HBP = 8;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int COLS = HA / 2;
  localparam int ROWS = VA / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_scanout_if vif ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vif  (vif)
  );

  always #5 clk = ~clk;

  logic [3:0] img [ROWS][COLS];
  int   ptr = 0;
  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  int   phase = 0;
  int   pmode = 0;
  logic pat_hist [4];
  int   rd_cnt, hs_run, vs_run, last_fall;
  logic prev_hs, prev_vs;

  // Stored image is ROWS x COLS; the read port replays each stored row for two screen lines.
  function automatic logic [3:0] fb_word(input int p);
    int line;
    line = (p / COLS) % VA;
    return img[line / 2][p % COLS];
  endfunction

  always @(posedge clk) begin
    if (vif.fb_reset_ptr) ptr <= 0;
    else if (vif.fb_read) ptr <= ptr + 1;
    vif.fb_data <= fb_word(ptr);
  end

  function automatic logic [11:0] pal(input logic [3:0] i);
    int ii;
    ii = int'(i);
    if (ii == 15) return 12'h000;
    return 12'(ii * 256 + ((ii * 2) % 16) * 16 + (15 - ii));
  endfunction

  task automatic fill_img(input bit random_fill);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        img[y][x] = random_fill ? 4'($urandom_range(0, 15)) : 4'(x % 16);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic reset_check();
    chk("rst_ctrl", {vif.hsync, vif.vsync, vif.de, vif.fb_read, vif.frame_start, vif.fb_reset_ptr}, 32'b110001);
    chk("rst_rgb", {vif.r, vif.g, vif.b}, 32'h0);
  endtask

  task automatic restart();
    n = 0;
    rd_cnt = 0;
    hs_run = 0;
    vs_run = 0;
    last_fall = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    for (int i = 0; i < 4; i++) pat_hist[i] = vif.pattern_en;
  endtask

  task automatic step();
    int hn, vn, q, hp, vp;
    logic de_e, hs_e, vs_e, rd_e, fs_e, rp_e;
    logic [3:0] idx;
    logic [11:0] rgb_e;
    @(negedge clk);
    hn = n % HT;
    vn = (n / HT) % VT;
    q  = (n + FT - 2) % FT;  // screen position whose pixel is at the output now
    hp = q % HT;
    vp = q / HT;
    de_e = (hp < HA) && (vp < VA);
    hs_e = !((hp >= HA + HFP) && (hp < HA + HFP + HS));
    vs_e = !((vp >= VA + VFP) && (vp < VA + VFP + VS));
    idx = 4'h0;
    if (de_e) idx = pat_hist[(n + 2) % 4] ? 4'((hp / 64) % 16) : img[vp / 2][hp / 2];
    rgb_e = de_e ? pal(idx) : 12'h000;
    rd_e = (hn < HA) && (vn < VA) && (hn % 2 == 1);
    fs_e = (hn == 0) && (vn == VA);
    rp_e = (n == 0) || fs_e;

    chk("timing", {vif.hsync, vif.vsync, vif.de}, {hs_e, vs_e, de_e});
    chk("rgb", {vif.r, vif.g, vif.b}, rgb_e);
    chk("fb_strobes", {vif.fb_read, vif.fb_reset_ptr, vif.frame_start}, {rd_e, rp_e, fs_e});

    if (phase == 0 && vp == 0 && hp == 6) chk("pal_idx3", {vif.r, vif.g, vif.b}, 32'h36C);
    if (phase == 0 && vp == 1 && hp == 31) chk("pal_idx15", {vif.r, vif.g, vif.b}, 32'h000);
    if (phase == 2 && vp == 3 && hp == 64) chk("bar_col64", {vif.r, vif.g, vif.b}, 32'h12E);
    if (phase == 2 && vp == 3 && hp == 127) chk("bar_col127", {vif.r, vif.g, vif.b}, 32'h12E);

    if (vif.fb_read) rd_cnt++;
    if (vif.frame_start) begin
      chk("reads_per_frame", rd_cnt, COLS * VA);
      rd_cnt = 0;
    end
    if (prev_hs && !vif.hsync) begin
      if (last_fall < 0) chk("first_hsync_fall", n, HA + HFP + 2);
      else chk("line_period", n - last_fall, HT);
      last_fall = n;
    end
    if (!vif.hsync) hs_run++;
    else if (!prev_hs) begin
      chk("hsync_width", hs_run, HS);
      hs_run = 0;
    end
    if (!vif.vsync) vs_run++;
    else if (!prev_vs) begin
      chk("vsync_width", vs_run, VS * HT);
      vs_run = 0;
    end
    prev_hs = vif.hsync;
    prev_vs = vif.vsync;

    @(posedge clk);
    n++;
    #1;
    case (pmode)
      0: vif.pattern_en = 1'b0;
      1: if ($urandom_range(0, 15) == 0) vif.pattern_en = !vif.pattern_en;
      default: vif.pattern_en = 1'b1;
    endcase
    pat_hist[n % 4] = vif.pattern_en;
    if ((n % HT == 0) && ((n / HT) % VT == VA)) fill_img(1'b1);
  endtask

  initial begin
    vif.pattern_en = 1'b0;
    fill_img(1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    restart();

    phase = 0; pmode = 0;
    repeat (FT) step();
    phase = 1; pmode = 1;
    repeat (FT) step();
    phase = 2; pmode = 2;
    repeat (FT) step();
    phase = 3; pmode = 1;
    repeat (FT) begin
      if ((n % FT) == 5 * HT + 100) break;
      step();
    end

    rst_n = 1'b0;
    #1;
    reset_check();
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;
    restart();
    phase = 4; pmode = 1;
    repeat (FT + 2 * HT) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
